// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response and the decode-side handshake.
// The master modport is the fetch unit; the slave modport is memory plus decode.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding memory request, and an in-order
// FIFO of {word, pc} entries feeding decode. A redirect flushes and restarts.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4            // power of two, >= 2
) (
    input  logic          clk,
    input  logic          reset_n,
    fetch_unit_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [31:0]     pc;
    logic [31:0]     req_pc;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   occ;
    logic            inflight;
    logic            drop;
    logic            reset_n_q;
    logic            grant;
    logic            push;
    logic            pop;

    // Space check counts the outstanding response but not a same-cycle pop.
    assign occ             = count + CW'(inflight);
    assign bus.imem_req    = reset_n_q & ~bus.redirect & (occ < CW'(DEPTH));
    assign bus.imem_addr   = pc;
    assign grant           = bus.imem_req & bus.imem_gnt;
    assign push            = bus.imem_rvalid & inflight & ~drop & ~bus.redirect;
    assign pop             = bus.instr_valid & bus.instr_ready & ~bus.redirect;

    assign bus.instr_valid = (count != '0);
    assign head            = bus.instr_valid ? mem[rd_ptr] : '0;
    assign bus.instr       = head.word;
    assign bus.instr_pc    = head.pc;

    always_ff @(posedge clk) begin
        reset_n_q <= reset_n;
        if (!reset_n) begin
            pc       <= {RESET_PC[31:2], 2'b00};
            req_pc   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
            drop     <= 1'b0;
        end else if (bus.redirect) begin
            pc       <= {bus.redirect_pc[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
            // A response still owed after the flush must be swallowed.
            drop     <= inflight & ~bus.imem_rvalid;
        end else begin
            inflight <= grant;
            drop     <= 1'b0;
            if (grant) begin
                pc     <= pc + 32'd4;
                req_pc <= pc;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; count gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (push && reset_n) mem[wr_ptr] <= {bus.imem_rdata, req_pc};
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: free-run, decode stall, redirects, memory stall,
// reset with a full FIFO, and PC wrap. Memory answers one cycle after grant.
module tb_fetch_unit;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk;
    logic        reset_n;
    logic        rv;
    logic [31:0] ra;
    logic        stale;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_pc;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: fixed one-cycle response; 'stale' injects a bogus response.
    always @(posedge clk) begin
        rv <= bus.imem_req & bus.imem_gnt;
        ra <= bus.imem_addr;
    end
    assign bus.imem_rvalid = rv | stale;
    assign bus.imem_rdata  = stale ? 32'hDEAD_BEEF : (ra ^ K);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ends one edge after release, when imem_req first rises.
    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; stale = 1'b0; rv = 1'b0; ra = '0;
        bus.imem_gnt = 1'b1; bus.instr_ready = 1'b1;
        bus.redirect = 1'b0; bus.redirect_pc = '0;

        // Reset state and free-run
        tick(); tick();
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_pc",    bus.instr_pc, 32'd0);
        chk("rst_req",   32'(bus.imem_req), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("fr_req",   32'(bus.imem_req), 32'd1);
        chk("fr_addr0", bus.imem_addr, 32'h0);
        tick();
        chk("fr_lat_valid", 32'(bus.instr_valid), 32'd0);
        chk("fr_addr4",     bus.imem_addr, 32'h4);
        exp_pc = 32'h0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("fr_valid", 32'(bus.instr_valid), 32'd1);
            chk("fr_pc",    bus.instr_pc, exp_pc);
            chk("fr_instr", bus.instr, exp_pc ^ K);
            exp_pc += 32'd4;
        end

        // Decode stall fills exactly DEPTH entries, then drains in order
        bus.instr_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        chk("st_valid", 32'(bus.instr_valid), 32'd1);
        chk("st_req",   32'(bus.imem_req), 32'd0);
        chk("st_head",  bus.instr_pc, 32'h0);
        chk("st_addr",  bus.imem_addr, 32'h10);
        bus.instr_ready = 1'b1;
        exp_pc = 32'h0;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_pc += 32'd4;
            chk("st_pc",    bus.instr_pc, exp_pc);
            chk("st_instr", bus.instr, exp_pc ^ K);
        end
        chk("st_addr_end", bus.imem_addr, 32'h20);

        // Redirect with a response in flight
        do_reset();
        tick();
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0103;
        #1;
        chk("rd_req_low", 32'(bus.imem_req), 32'd0);
        tick();
        bus.redirect = 1'b0;
        #1;
        chk("rd_valid",  32'(bus.instr_valid), 32'd0);
        chk("rd_req",    32'(bus.imem_req), 32'd1);
        chk("rd_addr",   bus.imem_addr, 32'h100);
        tick();
        chk("rd_valid2", 32'(bus.instr_valid), 32'd0);
        chk("rd_addr2",  bus.imem_addr, 32'h104);
        tick();
        chk("rd_pc",     bus.instr_pc, 32'h100);
        chk("rd_instr",  bus.instr, 32'hA5A5_0100);

        // Redirect coinciding with a decode handshake
        do_reset();
        tick(); tick();
        chk("rh_pre_valid", 32'(bus.instr_valid), 32'd1);
        chk("rh_pre_pc",    bus.instr_pc, 32'h0);
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0200;
        #1;
        chk("rh_req_low", 32'(bus.imem_req), 32'd0);
        tick();
        bus.redirect = 1'b0;
        #1;
        chk("rh_empty",    32'(bus.instr_valid), 32'd0);
        chk("rh_no_grant", 32'(rv), 32'd0);
        chk("rh_addr",     bus.imem_addr, 32'h200);
        chk("rh_req",      32'(bus.imem_req), 32'd1);
        tick(); tick();
        chk("rh_pc",       bus.instr_pc, 32'h200);

        // Memory stall: gnt 1,0,0,1
        do_reset();
        tick();
        bus.imem_gnt = 1'b0;
        #1;
        chk("ms_addr_b", bus.imem_addr, 32'h4);
        tick();
        chk("ms_addr_c", bus.imem_addr, 32'h4);
        chk("ms_req_c",  32'(bus.imem_req), 32'd1);
        chk("ms_pc0",    bus.instr_pc, 32'h0);
        tick();
        chk("ms_addr_d", bus.imem_addr, 32'h4);
        chk("ms_empty",  32'(bus.instr_valid), 32'd0);
        bus.imem_gnt = 1'b1;
        tick();
        chk("ms_addr_e", bus.imem_addr, 32'h8);
        tick();
        chk("ms_pc4",    bus.instr_pc, 32'h4);
        tick();
        chk("ms_pc8",    bus.instr_pc, 32'h8);

        // Reset with a full FIFO; stale response right after reset is ignored
        bus.instr_ready = 1'b0;
        do_reset();
        repeat (8) tick();
        chk("fr_full_valid", 32'(bus.instr_valid), 32'd1);
        chk("fr_full_req",   32'(bus.imem_req), 32'd0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; stale = 1'b1;
        #1;
        chk("rr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rr_instr", bus.instr, 32'd0);
        chk("rr_pc",    bus.instr_pc, 32'd0);
        chk("rr_req",   32'(bus.imem_req), 32'd0);
        tick();
        stale = 1'b0;
        #1;
        chk("rr_stale", 32'(bus.instr_valid), 32'd0);
        chk("rr_req2",  32'(bus.imem_req), 32'd1);
        chk("rr_addr",  bus.imem_addr, 32'h0);
        bus.instr_ready = 1'b1;
        tick(); tick();
        chk("rr_head_pc",    bus.instr_pc, 32'h0);
        chk("rr_head_instr", bus.instr, 32'hA5A5_0000);

        // PC wrap from the last word of the address space
        do_reset();
        bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
        tick();
        bus.redirect = 1'b0;
        #1;
        chk("wr_addr", bus.imem_addr, 32'hFFFF_FFFC);
        chk("wr_req",  32'(bus.imem_req), 32'd1);
        tick();
        chk("wr_wrap", bus.imem_addr, 32'h0);
        tick();
        chk("wr_pc",    bus.instr_pc, 32'hFFFF_FFFC);
        chk("wr_instr", bus.instr, 32'h5A5A_FFFC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction decode/control block.
- Holds the program counter and issues word requests to instruction memory.
- Buffers returned 32-bit instruction words, each tagged with its PC, in a small in-order FIFO.
- Presents them to decode over a valid/ready handshake.
- A redirect input from downstream flushes the FIFO and restarts fetch at a new target.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] are forced to 0.
- DEPTH, 4, number of FIFO entries; must be a power of two and at least 2.

Ports:
- clk  input  1  Single clock; all state updates on the rising edge.
- reset_n  input  1  Synchronous, active-low reset.
- imem_req  output  1  Fetch request valid.
- imem_addr  output  32  Byte address of the requested word; always equal to pc.
- imem_gnt  input  1  Memory accepts the request this cycle, if imem_req is high.
- imem_rvalid  input  1  Response valid; fixed at exactly one cycle after the grant.
- imem_rdata  input  32  Returned instruction word.
- instr_valid  output  1  FIFO head is valid.
- instr_ready  input  1  Decode accepts the head.
- instr  output  32  Head instruction word.
- instr_pc  output  32  PC of the head instruction.
- redirect  input  1  Flush and restart fetch.
- redirect_pc  input  32  New fetch address; bits [1:0] are ignored and treated as 0.

Behaviour:
- Reset (reset_n low at a clock edge):
  - pc = RESET_PC, count = 0, read and write pointers = 0, inflight = 0, drop = 0.
  - Outputs next cycle: instr_valid = 0, instr = 0, instr_pc = 0, imem_req = 0.
  - Reset mid-operation discards FIFO contents and any in-flight response; imem_rvalid is ignored during the first cycle after reset.
- Issue:
  - imem_req = reset_n_q & !redirect & (count + inflight < DEPTH), where reset_n_q is reset_n registered.
  - imem_req is combinational from registered state plus redirect.
  - A pop in the same cycle is not credited toward space (conservative).
- Grant: on imem_req & imem_gnt at an edge, pc <= pc + 4 (wraps modulo 2^32) and inflight <= 1. Otherwise inflight <= 0.
- Response:
  - On imem_rvalid & !drop, write {imem_rdata, pc_of_request} at the write pointer.
  - pc_of_request is the PC registered at grant.
  - The space rule guarantees the FIFO is never full on a write. If imem_rvalid arrives with inflight = 0, it is ignored.
- Output:
  - instr_valid = (count != 0); instr and instr_pc come from the head entry and are 0 when empty.
  - The FIFO is registered, so a response written at edge N is visible after edge N.
  - Minimum latency from grant edge to instr_valid is 2 edges.
- Pop: instr_valid & instr_ready & !redirect advances the read pointer. Simultaneous push and pop leaves count unchanged.
- Redirect (level, sampled at the edge):
  - pc <= {redirect_pc[31:2], 2'b00}, count <= 0, pointers <= 0.
  - drop <= inflight-pending. Any response arriving in the redirect cycle is discarded, and no new grant occurs in the redirect cycle.
  - A handshake in the redirect cycle is not a pop.
  - Back-to-back redirects: the last one wins.
  - Fetch resumes at the target the cycle after the redirect.
- Stall: while instr_ready is low, the FIFO fills to DEPTH and imem_req drops. Contents and order are preserved.
- Memory stall: imem_gnt low holds pc and imem_addr stable with imem_req high.
- Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.

Test Plan:
- Reset then free-run, with gnt = 1, ready = 1 and rdata = addr ^ 32'hA5A5_0000 → imem_addr 0,4,8,…; instr_valid first high 2 edges after the first grant; instr_pc 0,4,8 in order with matching instr.
- ready = 0 for 10 cycles → exactly DEPTH = 4 entries buffered, imem_req low after fill; on release, PCs 0,4,8,12 drain in order with no loss or duplication.
- redirect with redirect_pc = 32'h0000_0103 while a grant is in flight → in-flight response dropped; next imem_addr = 32'h100; first instr_pc after the redirect = 32'h100.
- redirect in the same cycle as instr_valid & instr_ready → head not counted as popped, FIFO empty next cycle, no grant in the redirect cycle.
- gnt toggled 1,0,0,1 → imem_addr held while gnt = 0; PCs delivered contiguous.
- reset_n low for 1 cycle with a full FIFO and a grant outstanding → instr_valid = 0 next cycle, stale rvalid ignored, fetch restarts at RESET_PC.
- pc = 32'hFFFF_FFFC via redirect → next fetch address 32'h0000_0000 (wrap).
